decoder38_scan: RTL and testbench
=================================

Name: decoder38_scan

Overview:
Sequential 3-to-8 decoder: turns a 3-bit index into a registered one-hot select line, the inverse of the 8-to-3 encoder path. Two modes: auto-scan, where an internal prescaler walks the index 0..7 (e.g. digit select for an 8-digit seven-segment display), and manual, where a host loads an index through a valid/ready handshake. Sits between control logic and display/peripheral select pins.

Parameters:
DIV, 4, clock cycles per scan step in auto mode; legal range 1..65535; DIV=1 steps every cycle
ACTIVE_LOW, 1, 1 = selected output bit driven 0 and others 1; 0 = selected bit 1, others 0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
iEn  input  1  1 = outputs active and scanning; 0 = blank and freeze
iMode  input  1  0 = auto-scan, 1 = manual load
iSel  input  3  manual index
iValid  input  1  manual load request
oReady  output  1  manual load accepted this cycle when iValid=1
oData  output  8  registered one-hot select (polarity per ACTIVE_LOW)
oIndex  output  3  registered current index
oWrap  output  1  one-cycle pulse when auto-scan steps 7->0

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: index=0, prescaler=0, oIndex=3'd0, oData=all-inactive (8'hFF if ACTIVE_LOW else 8'h00), oWrap=0, oReady=0.
- Inactive pattern: 8'hFF when ACTIVE_LOW=1, 8'h00 when ACTIVE_LOW=0. Active pattern for index k: only bit k is asserted.
- oData and oIndex are registered and update on the same edge. oData always equals decode(oIndex) while iEn=1, and equals the inactive pattern while iEn=0.
- Prescaler:
  - 16-bit counter, counts only when iEn=1 and iMode=0.
  - tick=1 when count==DIV-1; the count then wraps to 0.
  - The counter is cleared to 0 whenever iEn=0 or iMode=1.
- Auto mode (iMode=0, iEn=1):
  - On a tick edge, index <= index+1 mod 8.
  - oWrap=1 for exactly the cycle after a 7->0 step, otherwise 0.
  - First step comes DIV cycles after entering auto mode or after iEn rises.
- Manual mode (iMode=1, iEn=1):
  - oReady=1 combinationally; ticks are ignored; oWrap=0.
  - If iValid=1, iSel is captured on that edge. oIndex/oData show it after 1 cycle.
  - With iValid held, the captured value is updated every cycle.
- oReady=0 whenever iMode=0 or iEn=0. iValid is ignored while oReady=0.
- iEn=0:
  - index is held and the prescaler is cleared.
  - oData goes inactive on the next edge; oWrap=0.
  - When iEn returns to 1, oData shows the held index on the next edge.
- Mode switching:
  - Manual->auto: scanning resumes from the current index, first step DIV cycles later.
  - Auto->manual: the index is held and a pending tick is discarded.
- Simultaneous events: a mode change on the same edge as a tick uses the mode sampled at that edge. iValid in the auto-mode cycle is ignored.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Decomposition:
- Shared package: CODE_W=3, SEL_W=8, constants for the inactive patterns, and a pure decode function (3-bit index -> 8-bit one-hot, active-high) reused by future display/select blocks.
- One sub-module, tick_gen: parameter DIV; ports clk, rst_n, iClr, oTick. Holds the prescaler only.
- Index register, mode logic and output polarity live in decoder38_scan.

Test Plan:
1. Reset: rst_n=0 for 3 cycles, ACTIVE_LOW=1 -> oData=8'hFF, oIndex=0, oWrap=0, oReady=0; assert rst_n=0 asynchronously mid-scan -> same values immediately.
2. Auto scan, DIV=4, ACTIVE_LOW=0, iEn=1, iMode=0 for 40 cycles:
   - oData sequence is 8'h01, 8'h02, 8'h04, ... 8'h80, 8'h01, each value held 4 cycles.
   - oWrap pulses once, in the cycle oIndex becomes 0 after 7.
3. Manual load, iMode=1, ACTIVE_LOW=1: iValid=1 with iSel=5 for one cycle -> oReady=1; the next cycle oIndex=5 and oData=8'hDF. Then iValid=1 with iSel=2 -> oData=8'hFB.
4. Blanking: during auto scan at oIndex=3, drop iEn for 10 cycles:
   - oData goes inactive and oIndex stays 3.
   - Raise iEn -> oData=decode(3) the next edge, and the step to 4 comes 4 cycles later.
5. Handshake gating: iMode=0, iValid=1, iSel=6 -> oReady=0 and the index is unaffected. Switch to iMode=1 with iValid=1 on the same edge -> 6 is loaded, and no pending tick is applied.
6. DIV=1: iEn=1, iMode=0 -> oIndex increments every cycle 0..7,0, and oWrap asserts every 8th cycle.

Source files
------------

// File: rtl/decoder38_scan_pkg.sv
// decoder38_scan_pkg: shared widths, select patterns and index decode
// for the display/peripheral select blocks.
package decoder38_scan_pkg;

  localparam int CODE_W = 3;
  localparam int SEL_W  = 8;

  localparam logic [SEL_W-1:0] SEL_OFF_AH = 8'h00;
  localparam logic [SEL_W-1:0] SEL_OFF_AL = 8'hFF;

  // Active-high one-hot decode of a 3-bit index.
  function automatic logic [SEL_W-1:0] decode(
    input logic [CODE_W-1:0] k
  );
    logic [SEL_W-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder38_scan_tick.sv
// tick_gen: scan prescaler, one tick every DIV enabled cycles.
// Clearing restarts the count so a fresh run waits a full DIV.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic iClr,
  output logic oTick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign oTick = !iClr && (cnt_q == LAST);

  // Next count: clear, wrap on tick, else advance.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (iClr || oTick) begin
      cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder38_scan.sv
// decoder38_scan: registered 3-to-8 select with auto-scan and
// host-loaded manual index.
module decoder38_scan
  import decoder38_scan_pkg::*;
#(
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iEn,
  input  logic       iMode,
  input  logic [2:0] iSel,
  input  logic       iValid,
  output logic       oReady,
  output logic [7:0] oData,
  output logic [2:0] oIndex,
  output logic       oWrap
);

  localparam logic [SEL_W-1:0] OFF =
    ACTIVE_LOW ? SEL_OFF_AL : SEL_OFF_AH;

  logic              auto_w;
  logic              tick_w;
  logic [CODE_W-1:0] idx_q;
  logic [CODE_W-1:0] idx_d;
  logic [SEL_W-1:0]  data_q;
  logic [SEL_W-1:0]  data_d;
  logic              wrap_q;
  logic              wrap_d;
  logic [SEL_W-1:0]  hot_w;

  assign auto_w = iEn && !iMode;
  assign oReady = iEn && iMode;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .iClr  (!auto_w),
    .oTick (tick_w)
  );

  // Index advance on scan tick, or host load when accepted.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (auto_w && tick_w) begin
      idx_d  = idx_q + 3'd1;
      wrap_d = (idx_q == 3'd7);
    end else if (oReady && iValid) begin
      idx_d = iSel;
    end
  end

  // Output pattern follows the next index, blanked while disabled.
  always_comb begin
    hot_w  = decode(idx_d);
    data_d = OFF;
    if (iEn) begin
      data_d = ACTIVE_LOW ? ~hot_w : hot_w;
    end
  end

  // Index, select and wrap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      data_q <= OFF;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      wrap_q <= wrap_d;
    end
  end

  assign oIndex = idx_q;
  assign oData  = data_q;
  assign oWrap  = wrap_q;

endmodule

// File: tb/tb_decoder38_scan.sv
// tb_decoder38_scan: three configurations driven in lockstep and
// compared each cycle against a cycle-count reference model.
module tb_decoder38_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       valid;
  logic [2:0] sel;

  logic [2:0] rdy;
  logic [2:0] wrp;
  logic [7:0] dat [3];
  logic [2:0] idx [3];

  int total = 0;
  int bad   = 0;

  int m_div [3] = '{4, 4, 1};
  bit m_al  [3] = '{1'b1, 1'b0, 1'b1};
  int m_idx [3];
  int m_run [3];
  bit m_on  [3];
  bit m_wrap[3];
  int wraps [3];

  always #5 clk = ~clk;

  decoder38_scan #(.DIV(4), .ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .iEn(en), .iMode(mode),
    .iSel(sel), .iValid(valid), .oReady(rdy[0]),
    .oData(dat[0]), .oIndex(idx[0]), .oWrap(wrp[0])
  );

  decoder38_scan #(.DIV(4), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .iEn(en), .iMode(mode),
    .iSel(sel), .iValid(valid), .oReady(rdy[1]),
    .oData(dat[1]), .oIndex(idx[1]), .oWrap(wrp[1])
  );

  decoder38_scan #(.DIV(1), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .iEn(en), .iMode(mode),
    .iSel(sel), .iValid(valid), .oReady(rdy[2]),
    .oData(dat[2]), .oIndex(idx[2]), .oWrap(wrp[2])
  );

  task automatic chk(string tag, logic [15:0] got,
                     logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(int k, bit al, bit on);
    logic [7:0] p;
    p = on ? 8'(1 << k) : 8'h00;
    return al ? ~p : p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_idx[i]  = 0;
      m_run[i]  = 0;
      m_on[i]   = 1'b0;
      m_wrap[i] = 1'b0;
    end
  endtask

  // One clock edge: auto mode counts enabled cycles and steps
  // after every DIV of them; manual mode takes the host index.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = 1'b0;
      if (en && !mode) begin
        m_run[i]++;
        if (m_run[i] == m_div[i]) begin
          m_run[i]  = 0;
          m_wrap[i] = (m_idx[i] == 7);
          m_idx[i]  = (m_idx[i] + 1) % 8;
          if (m_wrap[i]) wraps[i]++;
        end
      end else begin
        m_run[i] = 0;
        if (en && mode && valid) m_idx[i] = int'(sel);
      end
      m_on[i] = en;
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d_idx", tag, i),
          16'(idx[i]), 16'(m_idx[i]));
      chk($sformatf("%s_u%0d_dat", tag, i), 16'(dat[i]),
          16'(pat(m_idx[i], m_al[i], m_on[i])));
      chk($sformatf("%s_u%0d_wrap", tag, i),
          16'(wrp[i]), 16'(m_wrap[i]));
    end
  endtask

  // Called at a negedge: drive, check ready, clock, check state.
  task automatic cyc(string tag, bit e, bit m, bit v,
                     logic [2:0] s);
    en = e; mode = m; valid = v; sel = s;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d_rdy", tag, i),
          16'(rdy[i]), 16'(e && m));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0;
    valid = 1'b0; sel = 3'd0;
    for (int i = 0; i < 3; i++) wraps[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("rst");
    chk("rst_u0_dat_ff", 16'(dat[0]), 16'h00FF);
    chk("rst_rdy", 16'(rdy), 16'h0);
    rst_n = 1'b1;

    // Free-running auto scan from index 0.
    for (int c = 0; c < 40; c++) cyc("auto", 1, 0, 0, 3'd0);
    chk("auto_wraps_d4", 16'(wraps[1]), 16'd1);
    chk("auto_wraps_d1", 16'(wraps[2]), 16'd5);
    chk("auto_u1_dat40", 16'(dat[1]), 16'h0004);

    // Asynchronous reset in the middle of a scan.
    for (int c = 0; c < 5; c++) cyc("pre", 1, 0, 0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst_u0_dat_ff", 16'(dat[0]), 16'h00FF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual loads through the handshake.
    cyc("man5", 1, 1, 1, 3'd5);
    chk("man5_u0_dat", 16'(dat[0]), 16'h00DF);
    cyc("man2", 1, 1, 1, 3'd2);
    chk("man2_u0_dat", 16'(dat[0]), 16'h00FB);
    cyc("manh", 1, 1, 0, 3'd7);

    // Blank at index 3, then resume.
    n = 0;
    while (m_idx[0] != 3 && n < 64) begin
      cyc("seek", 1, 0, 0, 3'd0);
      n++;
    end
    chk("seek_idx3", 16'(idx[0]), 16'd3);
    for (int c = 0; c < 10; c++) cyc("blank", 0, 0, 0, 3'd0);
    chk("blank_u0_dat", 16'(dat[0]), 16'h00FF);
    cyc("unbl", 1, 0, 0, 3'd0);
    chk("unbl_u0_dat", 16'(dat[0]), 16'h00F7);
    for (int c = 0; c < 3; c++) cyc("unbl", 1, 0, 0, 3'd0);
    chk("unbl_u0_step", 16'(idx[0]), 16'd4);

    // Handshake gating and auto->manual switch.
    cyc("gate", 1, 0, 1, 3'd6);
    cyc("gate", 1, 0, 1, 3'd6);
    cyc("sw", 1, 1, 1, 3'd6);
    chk("sw_u0_idx", 16'(idx[0]), 16'd6);
    for (int c = 0; c < 6; c++) cyc("hold", 1, 1, 0, 3'd1);
    chk("hold_u0_idx", 16'(idx[0]), 16'd6);

    // Randomized mixed traffic.
    for (int c = 0; c < 400; c++) begin
      cyc("rnd", ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 3) == 0), 1'($urandom),
          3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
